// File: rtl/axi_rd_arbiter.sv
// Two-master AXI read-channel arbiter (IFU = m0, LSU = m1) onto one slave read port.
// Optional macro AXI_ARB_RR_EN selects round-robin; otherwise LSU has fixed priority.
module axi_rd_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_busy,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m_rdata,
  output logic [3:0]        s_arid,
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rvalid,
  output logic              s_rready,
  output logic [1:0]        grant,
  output logic [1:0]        dbg_state,
  output logic              dbg_last
);

  // Handshakes: a transfer happens on a cycle where valid and ready are both high;
  // valid never waits on ready, and ready may depend combinationally on valid.
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [3:0]        arid_q, arid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              last_q, last_d;   // 1 = LSU was granted last
  logic              pick_m1;
  logic              owner_rready;

  always_comb begin
`ifdef AXI_ARB_RR_EN
    pick_m1 = m1_arvalid && (!m0_arvalid || !last_q);
`else
    pick_m1 = m1_arvalid;
`endif
  end

  assign owner_rready = grant_q[1] ? m1_rready : m0_rready;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    arid_d     = arid_q;
    araddr_d   = araddr_q;
    last_d     = last_q;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by reset so arready is forced low while reset is held.
        if (!reset && !wr_busy && (m0_arvalid || m1_arvalid)) begin
          m0_arready = !pick_m1;
          m1_arready = pick_m1;
          araddr_d   = pick_m1 ? m1_araddr : m0_araddr;
          arid_d     = {3'b000, pick_m1};
          grant_d    = pick_m1 ? 2'b10 : 2'b01;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        s_arvalid = 1'b1;
        if (s_arready) state_d = DATA;
      end
      DATA: begin
        s_rready  = owner_rready;
        m0_rvalid = grant_q[0] & s_rvalid;
        m1_rvalid = grant_q[1] & s_rvalid;
        if (s_rvalid && owner_rready) begin
          state_d = IDLE;
          grant_d = 2'b00;
          last_d  = grant_q[1];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= 2'b00;
      arid_q   <= 4'd0;
      araddr_q <= '0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      arid_q   <= arid_d;
      araddr_q <= araddr_d;
      last_q   <= last_d;
    end
  end

  assign m_rdata   = s_rdata;
  assign s_arid    = arid_q;
  assign s_araddr  = araddr_q;
  assign grant     = grant_q;
  assign dbg_state = state_q;
  assign dbg_last  = last_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: directed scenarios followed by random traffic,
// checked against a transaction-level model of the arbiter.
module tb_axi_rd_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int W  = 65;

  logic          clock = 1'b0;
  logic          reset, wr_busy;
  logic [AW-1:0] m0_araddr, m1_araddr, s_araddr;
  logic          m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic          m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [DW-1:0] m_rdata, s_rdata;
  logic [3:0]    s_arid;
  logic          s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0]    grant, dbg_state;
  logic          dbg_last;

  axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset), .wr_busy(wr_busy),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m_rdata(m_rdata), .s_arid(s_arid), .s_araddr(s_araddr), .s_arvalid(s_arvalid),
    .s_arready(s_arready), .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .grant(grant), .dbg_state(dbg_state), .dbg_last(dbg_last)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory contents seen by the slave; one fixed word for the IFU scenario.
  function automatic logic [63:0] mem_of(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h1122_3344_5566_7788;
    return {a[31:0], a[63:32]} ^ 64'h5A5A_0F0F_3C3C_9696;
  endfunction

  // ---------------- BFM configuration ----------------
  int            ar_delay = 0;
  int            r_delay  = 0;
  int            rr_pct   = 100;
  logic [63:0]   req_q0[$];
  logic [63:0]   req_q1[$];

  // Master drivers: present queued addresses, drop each on acceptance.
  initial begin
    m0_arvalid = 1'b0; m0_araddr = '0; m0_rready = 1'b0;
    m1_arvalid = 1'b0; m1_araddr = '0; m1_rready = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset && m0_arvalid && m0_arready) void'(req_q0.pop_front());
      if (!reset && m1_arvalid && m1_arready) void'(req_q1.pop_front());
      @(posedge clock); #1;
      m0_arvalid = (req_q0.size() > 0);
      m0_araddr  = (req_q0.size() > 0) ? req_q0[0] : '0;
      m1_arvalid = (req_q1.size() > 0);
      m1_araddr  = (req_q1.size() > 0) ? req_q1[0] : '0;
      m0_rready  = ($urandom_range(99) < rr_pct);
      m1_rready  = ($urandom_range(99) < rr_pct);
    end
  end

  // Slave driver: arready after ar_delay cycles of arvalid, data r_delay cycles later.
  initial begin
    int          ar_cnt;
    int          r_cnt;
    bit          r_pend;
    logic [63:0] r_addr;
    logic        nar, nrv;
    logic [63:0] nrd;
    ar_cnt = 0; r_cnt = 0; r_pend = 0; r_addr = '0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
    forever begin
      @(negedge clock);
      nrv = s_rvalid; nrd = s_rdata;
      if (reset) begin
        ar_cnt = 0; r_pend = 0; nrv = 1'b0;
      end else begin
        if (s_arvalid && s_arready) begin
          ar_cnt = 0; r_pend = 1; r_cnt = r_delay; r_addr = s_araddr;
        end else if (s_arvalid) begin
          ar_cnt++;
        end
        if (s_rvalid && s_rready) begin
          nrv = 1'b0; r_pend = 0;
        end else if (r_pend && !s_rvalid) begin
          if (r_cnt == 0) begin nrv = 1'b1; nrd = mem_of(r_addr); end
          else r_cnt--;
        end
      end
      nar = (ar_cnt >= ar_delay);
      @(posedge clock); #1;
      s_arready = nar; s_rvalid = nrv; s_rdata = nrd;
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [W-1:0] exp_q[$];        // {expected master id, expected data}
  logic         id_log[$];       // master id of each address handshake
  int           phase    = 0;    // 0 no read, 1 address pending at slave, 2 awaiting data
  logic         cur_id   = 1'b0;
  logic [63:0]  cur_addr = '0;
  logic         last_m   = 1'b1;
  int           done_cnt = 0;

  initial begin
    logic [1:0]   exp_ar;
    logic         win;
    logic         owner_rdy;
    logic [W-1:0] exp_t;
    forever begin
      @(negedge clock);
      if (reset) begin
        chk("reset_outs", 128'({m0_arready, m1_arready, m0_rvalid, m1_rvalid,
                                s_arvalid, s_rready, grant}), 128'(0));
        chk("reset_regs", 128'({s_arid, s_araddr}), 128'(0));
        chk("reset_last", 128'(dbg_last), 128'(1));
        phase = 0; last_m = 1'b1; exp_q.delete();
      end else begin
        exp_ar = 2'b00; win = 1'b0;
        if (phase == 0 && !wr_busy && (m0_arvalid || m1_arvalid)) begin
          if (m0_arvalid && m1_arvalid) begin
`ifdef AXI_ARB_RR_EN
            win = ~last_m;
`else
            win = 1'b1;
`endif
          end else begin
            win = m1_arvalid;
          end
          exp_ar = win ? 2'b10 : 2'b01;
        end
        owner_rdy = cur_id ? m1_rready : m0_rready;
        chk("arready", 128'({m1_arready, m0_arready}), 128'(exp_ar));
        chk("grant", 128'(grant), 128'((phase == 0) ? 2'b00 : (cur_id ? 2'b10 : 2'b01)));
        chk("s_arvalid", 128'(s_arvalid), 128'(phase == 1));
        chk("dbg_state", 128'(dbg_state), 128'(phase));
        if (phase == 1)
          chk("ar_id_addr", 128'({s_arid, s_araddr}), 128'({3'b000, cur_id, cur_addr}));
        chk("r_steer", 128'({m1_rvalid, m0_rvalid, s_rready}),
            128'((phase == 2) ? {cur_id & s_rvalid, ~cur_id & s_rvalid, owner_rdy} : 3'b000));
        chk("m_rdata", 128'(m_rdata), 128'(s_rdata));
        case (phase)
          0: if (exp_ar != 2'b00) begin
            phase    = 1;
            cur_id   = win;
            cur_addr = win ? m1_araddr : m0_araddr;
            exp_q.push_back({win, mem_of(cur_addr)});
          end
          1: if (s_arready) begin
            phase = 2;
            id_log.push_back(cur_id);
          end
          default: if (s_rvalid && owner_rdy) begin
            if (exp_q.size() == 0) begin
              total++; bad++;
              $display("FAIL r_pop: response with empty expected queue, got %0h", m_rdata);
            end else begin
              exp_t = exp_q.pop_front();
              chk("r_data", 128'({m1_rvalid, m_rdata}), 128'(exp_t));
            end
            phase = 0; last_m = cur_id; done_cnt++;
          end
        endcase
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin @(negedge clock); n++; end
    total++;
    if (done_cnt < target) begin
      bad++;
      $display("FAIL wait_done: got %0d completions expected %0d", done_cnt, target);
    end
  endtask

  task automatic wait_neg(input string name, input int budget, input int what);
    int n = 0;
    bit hit = 0;
    while (!hit && n < budget) begin
      @(negedge clock); n++;
      case (what)
        0: hit = m1_rvalid;
        default: hit = (dbg_state == 2'd2) && !s_rvalid;
      endcase
    end
    total++;
    if (!hit) begin bad++; $display("FAIL %s: timed out after %0d cycles, got 0 expected 1", name, n); end
  endtask

  task automatic do_reset();
    @(posedge clock); #1; reset = 1'b1;
    repeat (2) @(posedge clock);
    #1; reset = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          base;
    int          lbase;
    logic [2:0]  exp_ids;
    logic [63:0] a;
    reset = 1'b1; wr_busy = 1'b0;
    repeat (3) @(posedge clock);
    #1; reset = 1'b0;

    // IFU-only read of the fixed word
    base = done_cnt;
    req_q0.push_back(64'h8000_0000);
    wait_done(base + 1, 30);

    // Contested: both masters hold three requests each, starting from reset
    do_reset();
    id_log.delete();
    base = done_cnt;
    for (int i = 0; i < 3; i++) begin
      req_q0.push_back(64'h8000_0100 + 64'(i * 8));
      req_q1.push_back(64'h9000_0100 + 64'(i * 8));
    end
    wait_done(base + 6, 100);
`ifdef AXI_ARB_RR_EN
    exp_ids = 3'b010;
`else
    exp_ids = 3'b111;
`endif
    for (int i = 0; i < 3; i++)
      chk($sformatf("contest_id%0d", i), 128'((id_log.size() > i) ? id_log[i] : 1'bx),
          128'(exp_ids[2-i]));

    // Store ordering: wr_busy blocks the LSU for five cycles
    base = done_cnt;
    @(posedge clock); #1;
    wr_busy = 1'b1;
    req_q1.push_back(64'h9000_2000);
    @(posedge clock);
    repeat (5) begin
      @(negedge clock);
      chk("busy_block", 128'({m1_arvalid, m1_arready, s_arvalid}), 128'(3'b100));
    end
    @(posedge clock); #1;
    wr_busy = 1'b0;
    @(negedge clock);
    chk("busy_release", 128'(m1_arready), 128'(1));
    wait_done(base + 1, 30);

    // Response backpressure on the LSU
    base = done_cnt;
    rr_pct = 0;
    req_q1.push_back(64'h9000_3000);
    wait_neg("bp_rvalid", 30, 0);
    chk("bp_hold", 128'({s_rready, m1_rvalid, dbg_state}), 128'({1'b0, 1'b1, 2'd2}));
    repeat (2) begin
      @(negedge clock);
      chk("bp_hold", 128'({s_rready, m1_rvalid, dbg_state}), 128'({1'b0, 1'b1, 2'd2}));
    end
    rr_pct = 100;
    @(negedge clock);
    chk("bp_release", 128'({s_rready, m1_rvalid}), 128'(2'b11));
    @(negedge clock);
    chk("bp_idle", 128'(dbg_state), 128'(0));
    wait_done(base + 1, 10);

    // Slow slave while the IFU moves on to a new address
    base = done_cnt;
    ar_delay = 4;
    req_q0.push_back(64'h8000_0000);
    req_q0.push_back(64'h8000_1000);
    for (int n = 0; n < 20 && done_cnt == base; n++) begin
      @(negedge clock);
      if (dbg_state == 2'd1) chk("slow_addr", 128'(s_araddr), 128'(64'h8000_0000));
    end
    wait_done(base + 2, 60);
    ar_delay = 0;

    // Asynchronous reset in the data phase
    r_delay = 3;
    req_q0.push_back(64'h8000_4000);
    wait_neg("rst_data", 30, 1);
    chk("pre_rst", 128'({s_rready, grant}), 128'(3'b101));
    #2; reset = 1'b1;
    #1;
    chk("rst_async", 128'({m0_arready, m1_arready, m0_rvalid, m1_rvalid,
                           s_arvalid, s_rready, grant}), 128'(0));
    repeat (2) @(posedge clock);
    #1; reset = 1'b0; r_delay = 0;
    base = done_cnt;
    id_log.delete();
    req_q0.push_back(64'h8000_5000);
    wait_done(base + 1, 30);
    chk("post_rst_id", 128'((id_log.size() > 0) ? id_log[0] : 1'bx), 128'(0));

    // Random traffic
    rr_pct = 70;
    for (int c = 0; c < 600; c++) begin
      @(posedge clock); #1;
      wr_busy  = ($urandom_range(5) == 0);
      ar_delay = $urandom_range(2);
      r_delay  = $urandom_range(2);
      if (req_q0.size() < 2 && $urandom_range(3) == 0) begin
        a = {$urandom, $urandom} & ~64'h7;
        req_q0.push_back(a);
      end
      if (req_q1.size() < 2 && $urandom_range(3) == 0) begin
        a = {$urandom, $urandom} & ~64'h7;
        req_q1.push_back(a);
      end
    end
    @(posedge clock); #1;
    wr_busy = 1'b0; rr_pct = 100; ar_delay = 0; r_delay = 0;
    lbase = 0;
    while ((req_q0.size() > 0 || req_q1.size() > 0 || phase != 0) && lbase < 2000) begin
      @(negedge clock); lbase++;
    end
    chk("drain", 128'({req_q0.size() == 0, req_q1.size() == 0, phase == 0}), 128'(3'b111));
    @(negedge clock);
    chk("exp_q_empty", 128'(exp_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Two-master read-channel arbiter between the core's instruction fetch unit (master 0, IFU) and load/store unit (master 1, LSU) and the single AXI read slave port of the memory model. It accepts one read address at a time from the winning master, replays it to the slave, and steers the read response back. It blocks new grants while a store is in flight, so loads never overtake stores at memory.

## Interface
Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- wr_busy  in  1  write transaction in flight on the slave write channel; inhibits new read grants
- m0_araddr  in  ADDR_W  IFU read address
- m0_arvalid  in  1  IFU address valid
- m0_arready  out  1  IFU address accepted
- m0_rvalid  out  1  IFU read data valid
- m0_rready  in  1  IFU read data ready
- m1_araddr  in  ADDR_W  LSU read address
- m1_arvalid  in  1  LSU address valid
- m1_arready  out  1  LSU address accepted
- m1_rvalid  out  1  LSU read data valid
- m1_rready  in  1  LSU read data ready
- m_rdata  out  DATA_W  shared read data to both masters; always equals s_rdata
- s_arid  out  4  transaction ID: 4'd0 = IFU, 4'd1 = LSU
- s_araddr  out  ADDR_W  registered slave address
- s_arvalid  out  1  slave address valid
- s_arready  in  1  slave address ready
- s_rdata  in  DATA_W  slave read data
- s_rvalid  in  1  slave read data valid
- s_rready  out  1  slave read data ready
- grant  out  2  one-hot owner of the current transaction (bit0 = IFU, bit1 = LSU); 0 when idle

## Operation
- State machine: IDLE → ADDR → DATA → IDLE. Exactly one transaction is outstanding at any time.
- IDLE:
  - If wr_busy=0 and any mX_arvalid=1, pick a winner and drive its mX_arready=1 combinationally in that cycle.
  - On that cycle's clock edge: latch the winner's araddr into s_araddr, set s_arid and grant, go to ADDR.
  - If wr_busy=1, no arready is driven and the state stays IDLE.
- ADDR: s_arvalid=1 with the latched address and ID. On s_arready=1, go to DATA. Master inputs are ignored in this state.
- DATA:
  - Granted master's mX_rvalid = s_rvalid, and s_rready = that master's mX_rready.
  - Ungranted master's rvalid is 0.
  - On s_rvalid & s_rready, go to IDLE, clear grant, and record the winner as the last-granted master.
- Default arbitration is fixed priority: LSU (m1) beats IFU (m0) when both request in the same cycle.
- wr_busy changing during ADDR or DATA has no effect on the in-flight read.
- Reset values:
  - state = IDLE; grant, s_arid, s_araddr = 0.
  - s_arvalid, s_rready, m0/m1_arready, m0/m1_rvalid = 0.
  - last-granted = m1.

## Timing
- Address accept: mX_arready is high in the same cycle as the request, when in IDLE with wr_busy=0.
- s_arvalid rises the cycle after the accept.
- s_araddr and s_arid stay stable from ADDR entry until the R handshake completes.
- Response path (s_rvalid → mX_rvalid, mX_rready → s_rready, s_rdata → m_rdata) is combinational: zero cycles.
- Back-to-back reads:
  - After an R handshake the state is IDLE on the next cycle, and a new accept can happen in that cycle.
  - Minimum 3 cycles per transaction with a zero-wait slave.
- Reset asserted mid-transaction:
  - All outputs go to their reset values immediately (asynchronous).
  - The in-flight transaction is dropped; the system resets the slave together with this block.

## Configuration
- AXI_ARB_RR_EN defined: round-robin arbitration.
  - When both masters request, the one not last-granted wins.
  - First contested grant after reset goes to m0.
- AXI_ARB_RR_EN undefined: fixed priority, m1 over m0. The last-granted register is present but does not affect selection.

## Test plan
- IFU-only read: m0_araddr=0x80000000 and m0_arvalid held; slave returns 0x1122334455667788.
  - Required: m0_arready in the request cycle.
  - Required: next cycle s_arvalid=1, s_araddr=0x80000000, s_arid=0, grant=2'b01.
  - Required: m0_rvalid with m_rdata=0x1122334455667788; m1_rvalid stays 0 throughout.
- Contested reads: m0 and m1 both request continuously for three transactions.
  - Without the macro: grants are LSU, LSU, LSU (s_arid=1 each time).
  - With AXI_ARB_RR_EN: grants are IFU, LSU, IFU (s_arid=0,1,0).
- Store ordering: wr_busy=1 for 5 cycles while m1_arvalid=1.
  - Required: m1_arready=0 and s_arvalid=0 for all 5 cycles.
  - Required: accept in the first cycle after wr_busy falls.
- Response backpressure: s_rvalid=1 while m1_rready=0 for 3 cycles.
  - Required: s_rready=0, state holds DATA, m1_rvalid=1.
  - Required: transaction completes in the cycle m1_rready rises.
- Slow slave: s_arready delayed 4 cycles while m0 changes m0_araddr to 0x80001000.
  - Required: s_araddr stays at the latched 0x80000000.
  - Required: no second m0_arready until the R handshake completes.
- Reset during DATA: assert reset.
  - Required: s_rready, s_arvalid, and all rvalid/arready outputs go to 0 with no clock edge; grant=0.
  - Required: after release, a new m0 read completes normally with s_arid=0.
